// File: rtl/cook_pkg.sv
// cook_pkg: shared types and constants for the cook_timer block.
//   state_t  - controller states
//   bcd_t    - one BCD digit
//   mmss_t   - packed {m10, m1, s10, s1} time value, 16 bits
//   BCD_NINE / SEC_TENS_MAX - reload values used when a digit borrows
package cook_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    RUN,
    HOLD,
    DONE
  } state_t;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t m10;
    bcd_t m1;
    bcd_t s10;
    bcd_t s1;
  } mmss_t;

  localparam bcd_t BCD_NINE     = 4'd9;
  localparam bcd_t SEC_TENS_MAX = 4'd5;

  // Keypad codes 10..15 are not decimal digits and are dropped.
  function automatic logic is_digit(input bcd_t d);
    return d <= BCD_NINE;
  endfunction

endpackage

// File: rtl/bcd_time_dec.sv
// bcd_time_dec: combinational one-second decrement of an mm:ss BCD time.
//   t_in  [15:0] - current time {m10, m1, s10, s1}
//   t_out [15:0] - time minus one second
//   zero         - t_out is 00:00
// Seconds-tens borrows reload to 5; any other borrow reloads 9. A seconds-tens
// digit of 6..9 (possible from keypad entry) simply counts down like any digit.
module bcd_time_dec
  import cook_pkg::*;
(
  input  logic [15:0] t_in,
  output logic [15:0] t_out,
  output logic        zero
);

  mmss_t a;
  mmss_t y;

  assign a = t_in;

  always_comb begin
    y = a;
    if (a.s1 != '0) begin
      y.s1 = a.s1 - 4'd1;
    end else begin
      y.s1 = BCD_NINE;
      if (a.s10 != '0) begin
        y.s10 = a.s10 - 4'd1;
      end else begin
        y.s10 = SEC_TENS_MAX;
        if (a.m1 != '0) begin
          y.m1 = a.m1 - 4'd1;
        end else begin
          y.m1  = BCD_NINE;
          y.m10 = a.m10 - 4'd1;
        end
      end
    end
  end

  assign t_out = y;
  assign zero  = (y == '0);

endmodule

// File: rtl/cook_timer.sv
// cook_timer: microwave-style countdown timer with keypad entry.
//   clk         - system clock, rising edge
//   nrst        - asynchronous active-low reset
//   heat        - cooking active request from the oven controller
//   tick        - 1 Hz one-cycle strobe (unused when the prescaler is built in)
//   digit_valid - keypad strobe
//   digit [3:0] - keypad BCD value (10..15 ignored)
//   clear       - clear-time command
//   finish      - one-cycle pulse when the cooking time expires
//   running     - high in RUN
//   disp [15:0] - remaining time {m10, m1, s10, s1}
// Build option: define COOK_TIMER_PRESCALER_EN to derive the tick internally
// from clk (one tick per TICK_DIV cycles in RUN) and ignore the tick input.
module cook_timer
  import cook_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        heat,
  input  logic        tick,
  input  logic        digit_valid,
  input  logic [3:0]  digit,
  input  logic        clear,
  output logic        finish,
  output logic        running,
  output logic [15:0] disp
);

  state_t      state_q, state_d;
  logic [15:0] disp_q, disp_d;
  logic        fin_q, fin_d;
  logic        tick_eff;
  logic        key_ok;
  logic [15:0] dec_val;
  logic        dec_zero;

  bcd_time_dec u_dec (
    .t_in  (disp_q),
    .t_out (dec_val),
    .zero  (dec_zero)
  );

`ifdef COOK_TIMER_PRESCALER_EN
  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] presc_q;
  logic          presc_wrap;
  logic          unused_tick;

  assign unused_tick = tick;
  assign presc_wrap  = (presc_q == CW'(TICK_DIV - 1));

  // Held at zero outside RUN, so every entry into RUN starts a full period.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      presc_q <= '0;
    end else if (state_q != RUN || presc_wrap) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + CW'(1);
    end
  end

  assign tick_eff = (state_q == RUN) && presc_wrap;
`else
  logic [31:0] unused_tick_div;

  assign unused_tick_div = TICK_DIV;
  assign tick_eff        = tick;
`endif

  assign key_ok = digit_valid && is_digit(digit);

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      disp_q  <= '0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      disp_q  <= disp_d;
      fin_q   <= fin_d;
    end
  end

  // Next-state logic. finish is registered alongside the transition into
  // DONE, so it rises in the same cycle disp reads 0000.
  always_comb begin
    state_d = state_q;
    disp_d  = disp_q;
    fin_d   = 1'b0;
    case (state_q)
      IDLE, ENTRY: begin
        if (clear) begin
          state_d = IDLE;
          disp_d  = '0;
        end else if (heat) begin
          if (disp_q != '0) begin
            state_d = RUN;
          end else begin
            state_d = DONE;
            fin_d   = 1'b1;
          end
        end else if (key_ok) begin
          disp_d  = {disp_q[11:0], digit};
          state_d = ENTRY;
        end
      end
      RUN: begin
        if (!heat) begin
          state_d = HOLD;
        end else if (tick_eff) begin
          disp_d = dec_val;
          if (dec_zero) begin
            state_d = DONE;
            fin_d   = 1'b1;
          end
        end
      end
      HOLD: begin
        if (clear) begin
          state_d = IDLE;
          disp_d  = '0;
        end else if (heat) begin
          // Keys pressed during HOLD may have zeroed the time; expire
          // immediately rather than wrapping the decrement.
          if (disp_q != '0) begin
            state_d = RUN;
          end else begin
            state_d = DONE;
            fin_d   = 1'b1;
          end
        end else if (key_ok) begin
          disp_d = {disp_q[11:0], digit};
        end
      end
      DONE: begin
        if (clear || !heat) begin
          state_d = IDLE;
          disp_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        disp_d  = '0;
      end
    endcase
  end

  // Outputs
  always_comb begin
    running = (state_q == RUN);
    finish  = fin_q;
    disp    = disp_q;
  end

endmodule

// File: tb/tb_cook_timer.sv
// tb_cook_timer: directed self-checking bench for cook_timer.
module tb_cook_timer;

  logic        clk = 1'b0;
  logic        nrst = 1'b1;
  logic        heat = 1'b0;
  logic        tick = 1'b0;
  logic        digit_valid = 1'b0;
  logic [3:0]  digit = 4'd0;
  logic        clear = 1'b0;
  logic        finish;
  logic        running;
  logic [15:0] disp;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cook_timer #(.TICK_DIV(4)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .heat        (heat),
    .tick        (tick),
    .digit_valid (digit_valid),
    .digit       (digit),
    .clear       (clear),
    .finish      (finish),
    .running     (running),
    .disp        (disp)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] d);
    digit_valid = 1'b1;
    digit       = d;
    cyc();
    digit_valid = 1'b0;
  endtask

  task automatic tk();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  function automatic logic [15:0] secs_to_bcd(input int unsigned r);
    int unsigned m;
    int unsigned s;
    m = r / 60;
    s = r % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  initial begin
    #2 nrst = 1'b0;
    #1;
    chk("rst_disp", disp, 16'h0000);
    chk("rst_finish", finish, 0);
    chk("rst_running", running, 0);
    cyc();
    cyc();
    nrst = 1'b1;

    // keypad shift, m10 discarded on the fifth key
    key(4'd1);
    chk("key_first", disp, 16'h0001);
    key(4'd2); key(4'd3); key(4'd4); key(4'd5);
    chk("key_shift", disp, 16'h2345);
    key(4'd12);
    chk("key_invalid", disp, 16'h2345);
    clear = 1'b1; cyc(); clear = 1'b0;
    chk("clear_entry", disp, 16'h0000);
    key(4'd7);
    chk("key_7", disp, 16'h0007);
    clear = 1'b1; digit_valid = 1'b1; digit = 4'd7;
    cyc();
    clear = 1'b0; digit_valid = 1'b0;
    chk("clear_wins", disp, 16'h0000);

    // heat with zero time
    heat = 1'b1; cyc();
    chk("zero_heat_finish", finish, 1);
    chk("zero_heat_running", running, 0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("zero_heat_no_repeat", finish, 0);
    end
    heat = 1'b0; cyc();
    chk("zero_heat_release", finish, 0);
    key(4'd7);
    chk("idle_after_done", disp, 16'h0007);
    clear = 1'b1; cyc(); clear = 1'b0;

    // asynchronous reset mid-RUN
    key(4'd4); key(4'd2);
    heat = 1'b1; cyc();
    chk("pre_rst_running", running, 1);
    chk("pre_rst_disp", disp, 16'h0042);
    #2 nrst = 1'b0; heat = 1'b0;
    #1;
    chk("async_rst_disp", disp, 16'h0000);
    chk("async_rst_running", running, 0);
    chk("async_rst_finish", finish, 0);
    cyc();
    nrst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("post_rst_finish", finish, 0);
      chk("post_rst_disp", disp, 16'h0000);
    end
    key(4'd3);
    chk("post_rst_idle", disp, 16'h0003);
    clear = 1'b1; cyc(); clear = 1'b0;

`ifdef COOK_TIMER_PRESCALER_EN
    // internal prescaler, TICK_DIV=4; tick input held high to show it is ignored
    key(4'd3);
    heat = 1'b1; tick = 1'b1; cyc();
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("presc_wait1", disp, 16'h0003);
    end
    cyc();
    chk("presc_dec1", disp, 16'h0002);
    heat = 1'b0; cyc();
    chk("presc_hold", running, 0);
    heat = 1'b1; cyc();
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("presc_wait2", disp, 16'h0002);
    end
    cyc();
    chk("presc_dec2", disp, 16'h0001);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("presc_wait3", finish, 0);
    end
    cyc();
    chk("presc_end_disp", disp, 16'h0000);
    chk("presc_end_finish", finish, 1);
    tick = 1'b0; heat = 1'b0; cyc();
`else
    // 01:30 counts down 90 seconds
    key(4'd1); key(4'd3); key(4'd0);
    chk("load_0130", disp, 16'h0130);
    heat = 1'b1; cyc();
    chk("run_0130", running, 1);
    for (int i = 1; i <= 90; i++) begin
      tk();
      chk("cd_disp", disp, secs_to_bcd(90 - i));
      chk("cd_finish", finish, (i == 90) ? 16'd1 : 16'd0);
    end
    chk("cd_done_running", running, 0);
    cyc();
    chk("cd_finish_once", finish, 0);
    key(4'd5);
    chk("done_ignores_key", disp, 16'h0000);
    heat = 1'b0; cyc();
    key(4'd5);
    chk("idle_key_0005", disp, 16'h0005);

    // pause/resume with a tick on the pausing edge
    heat = 1'b1; cyc();
    tk(); tk();
    chk("run_0003", disp, 16'h0003);
    heat = 1'b0; tick = 1'b1; cyc(); tick = 1'b0;
    chk("hold_tick_ignored", disp, 16'h0003);
    chk("hold_running", running, 0);
    tk();
    chk("hold_tick2", disp, 16'h0003);
    heat = 1'b1; cyc();
    chk("resume_running", running, 1);
    tk();
    chk("resume_0002", disp, 16'h0002);
    chk("resume_nofin", finish, 0);
    tk(); tk();
    chk("resume_end_disp", disp, 16'h0000);
    chk("resume_finish", finish, 1);
    heat = 1'b0; cyc();

    // borrow cases and clear in RUN
    key(4'd1); key(4'd0); key(4'd0);
    heat = 1'b1; cyc();
    tk();
    chk("borrow_0100", disp, 16'h0059);
    clear = 1'b1; cyc(); clear = 1'b0;
    chk("clear_in_run", disp, 16'h0059);
    chk("clear_in_run_running", running, 1);
    heat = 1'b0; cyc();
    clear = 1'b1; cyc(); clear = 1'b0;
    chk("clear_in_hold", disp, 16'h0000);
    key(4'd1); key(4'd0); key(4'd0); key(4'd0);
    heat = 1'b1; cyc();
    tk();
    chk("borrow_1000", disp, 16'h0959);
    heat = 1'b0; cyc();
    clear = 1'b1; cyc(); clear = 1'b0;
    key(4'd1); key(4'd9); key(4'd0);
    heat = 1'b1; cyc();
    tk();
    chk("s10_nine_a", disp, 16'h0189);
    tk();
    chk("s10_nine_b", disp, 16'h0188);
    heat = 1'b0; cyc();
    clear = 1'b1; cyc(); clear = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
